// File: rtl/uf_label_scheduler_pkg.sv
// Shared definitions for the union-find label scheduler.
// Holds the engine opcodes, the scheduler FSM state encoding and a small
// helper that classifies states belonging to the resolve sweep.
package uf_label_scheduler_pkg;

  localparam logic [1:0] UF_OP_IDLE  = 2'b00;
  localparam logic [1:0] UF_OP_UNION = 2'b01;
  localparam logic [1:0] UF_OP_FIND  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_U_ISSUE = 3'd1,
    S_U_WAIT  = 3'd2,
    S_F_ISSUE = 3'd3,
    S_F_WAIT  = 3'd4,
    S_CLEAR   = 3'd5
  } sched_state_e;

  // True while the find sweep (or its closing clear) owns the engine.
  function automatic logic is_resolving(input sched_state_e s);
    return (s == S_F_ISSUE) || (s == S_F_WAIT) || (s == S_CLEAR);
  endfunction

endpackage

// File: rtl/uf_label_scheduler_if.sv
// Equivalence-pair stream from the raster labeller to the scheduler.
// Signals:
//   pair_valid / pair_ready : handshake, transfer when both are 1
//   pair_a / pair_b         : the two equivalent labels
//   frame_end               : 1-cycle pulse, last pair of the frame already offered
// Modports: master = labeller side, slave = scheduler side.
interface uf_label_scheduler_if #(
  parameter int ADDR_WIDTH = 8
) ();

  logic                  pair_valid;
  logic                  pair_ready;
  logic [ADDR_WIDTH-1:0] pair_a;
  logic [ADDR_WIDTH-1:0] pair_b;
  logic                  frame_end;

  modport master (output pair_valid, output pair_a, output pair_b, output frame_end,
                  input  pair_ready);
  modport slave  (input  pair_valid, input  pair_a, input  pair_b, input  frame_end,
                  output pair_ready);

endinterface

// File: rtl/uf_label_scheduler_equiv_pair_fifo.sv
// Synchronous FIFO buffering equivalence pairs ahead of the union-find engine.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset (FIFO empties)
//   push_i, wdata_i   : write request and data
//   pop_i, rdata_o    : read request and head-of-queue data (show-ahead)
//   full_o, empty_o   : occupancy flags
// A push while full is accepted only when a pop frees the slot in the same cycle;
// a pop while empty is ignored.
module uf_label_scheduler_equiv_pair_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW:0]      wr_ptr_q;
  logic [PW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rd_ptr_q[PW-1:0]];

  // Pointer update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= {(PW+1){1'b0}};
      rd_ptr_q <= {(PW+1){1'b0}};
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Storage array; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uf_label_scheduler.sv
// Union-find label scheduler for connected-component labelling.
// Buffers equivalence pairs and issues them as UNION ops; at frame end drains
// the buffer, sweeps every label with FIND ops and writes each root into the
// label-resolve LUT, then pulses uf_clear to reset the engine for the next frame.
// Ports:
//   clk, reset                : clock, asynchronous active-high reset
//   pair_if (slave)           : equivalence-pair stream + frame_end
//   uf_op/uf_node1/uf_node2   : engine command (00 idle, 01 union, 10 find)
//   uf_result/uf_done/uf_idle : engine response
//   uf_clear                  : 1-cycle engine clear pulse after a sweep
//   lut_wr_en/addr/data       : LUT write port (label -> root)
//   resolve_done              : 1-cycle pulse after the last LUT write
//   busy                      : FSM active or pairs still buffered
//   frame_overrun             : sticky, frame_end arrived while one was pending/resolving
module uf_label_scheduler
  import uf_label_scheduler_pkg::*;
#(
  parameter int N_LABELS   = 256,
  parameter int ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  uf_label_scheduler_if.slave   pair_if,
  output logic [1:0]            uf_op,
  output logic [ADDR_WIDTH-1:0] uf_node1,
  output logic [ADDR_WIDTH-1:0] uf_node2,
  input  logic [ADDR_WIDTH-1:0] uf_result,
  input  logic                  uf_done,
  input  logic                  uf_idle,
  output logic                  uf_clear,
  output logic                  lut_wr_en,
  output logic [ADDR_WIDTH-1:0] lut_wr_addr,
  output logic [ADDR_WIDTH-1:0] lut_wr_data,
  output logic                  resolve_done,
  output logic                  busy,
  output logic                  frame_overrun
);

  // One extra bit so a sweep over 2^ADDR_WIDTH labels ends without wrapping.
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_LABELS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  sched_state_e          state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  pending_q;
  logic                  run_q;
  logic                  overrun_q;
  logic [1:0]            uf_op_q;
  logic [ADDR_WIDTH-1:0] node1_q;
  logic [ADDR_WIDTH-1:0] node2_q;
  logic                  uf_clear_q;
  logic                  lut_wr_en_q;
  logic [ADDR_WIDTH-1:0] lut_addr_q;
  logic [ADDR_WIDTH-1:0] lut_data_q;
  logic                  resolve_done_q;

  logic                    resolving;
  logic                    ready;
  logic                    push;
  logic                    pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [2*ADDR_WIDTH-1:0] head;
  logic [ADDR_WIDTH-1:0]   head_a;
  logic [ADDR_WIDTH-1:0]   head_b;
  logic                    fe_accept;
  logic                    fe_overrun;

  assign resolving = is_resolving(state_q);
  // run_q keeps ready low while reset is applied and for the first cycle after.
  assign ready     = run_q & ~fifo_full & ~pending_q & ~resolving;
  assign push      = pair_if.pair_valid & ready;
  // The pop happens in the same cycle the union is registered for issue.
  assign pop       = (state_q == S_U_ISSUE) & uf_idle;
  assign head_a    = head[2*ADDR_WIDTH-1:ADDR_WIDTH];
  assign head_b    = head[ADDR_WIDTH-1:0];
  assign fe_accept  = pair_if.frame_end & ~pending_q & ~resolving;
  assign fe_overrun = pair_if.frame_end & (pending_q | resolving);

  assign pair_if.pair_ready = ready;
  assign uf_op         = uf_op_q;
  assign uf_node1      = node1_q;
  assign uf_node2      = node2_q;
  assign uf_clear      = uf_clear_q;
  assign lut_wr_en     = lut_wr_en_q;
  assign lut_wr_addr   = lut_addr_q;
  assign lut_wr_data   = lut_data_q;
  assign resolve_done  = resolve_done_q;
  assign frame_overrun = overrun_q;
  assign busy          = (state_q != S_IDLE) | ~fifo_empty;

  uf_label_scheduler_equiv_pair_fifo #(
    .WIDTH (2*ADDR_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i ({pair_if.pair_a, pair_if.pair_b}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Scheduler FSM with sweep counter, engine driver and LUT writer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= {CNT_W{1'b0}};
      pending_q      <= 1'b0;
      run_q          <= 1'b0;
      overrun_q      <= 1'b0;
      uf_op_q        <= UF_OP_IDLE;
      node1_q        <= {ADDR_WIDTH{1'b0}};
      node2_q        <= {ADDR_WIDTH{1'b0}};
      uf_clear_q     <= 1'b0;
      lut_wr_en_q    <= 1'b0;
      lut_addr_q     <= {ADDR_WIDTH{1'b0}};
      lut_data_q     <= {ADDR_WIDTH{1'b0}};
      resolve_done_q <= 1'b0;
    end else begin
      run_q          <= 1'b1;
      // Commands and strobes are single-cycle unless set again below.
      uf_op_q        <= UF_OP_IDLE;
      uf_clear_q     <= 1'b0;
      lut_wr_en_q    <= 1'b0;
      resolve_done_q <= 1'b0;
      if (fe_overrun) overrun_q <= 1'b1;
      if (fe_accept)  pending_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          // Buffered unions always drain before the sweep may start.
          if (!fifo_empty)    state_q <= S_U_ISSUE;
          else if (pending_q) state_q <= S_F_ISSUE;
          else                state_q <= S_IDLE;
        end
        S_U_ISSUE: begin
          if (uf_idle) begin
            if (head_a != head_b) begin
              uf_op_q <= UF_OP_UNION;
              node1_q <= head_a;
              node2_q <= head_b;
              state_q <= S_U_WAIT;
            end else begin
              // Self-equivalence carries no information: drop it.
              state_q <= S_IDLE;
            end
          end
        end
        S_U_WAIT: begin
          if (uf_done) state_q <= S_IDLE;
        end
        S_F_ISSUE: begin
          if (uf_idle) begin
            uf_op_q <= UF_OP_FIND;
            node1_q <= cnt_q[ADDR_WIDTH-1:0];
            node2_q <= {ADDR_WIDTH{1'b0}};
            state_q <= S_F_WAIT;
          end
        end
        S_F_WAIT: begin
          if (uf_done) begin
            lut_wr_en_q <= 1'b1;
            lut_addr_q  <= cnt_q[ADDR_WIDTH-1:0];
            lut_data_q  <= uf_result;
            if (cnt_q == CNT_LAST) begin
              state_q <= S_CLEAR;
            end else begin
              cnt_q   <= cnt_q + CNT_ONE;
              state_q <= S_F_ISSUE;
            end
          end
        end
        S_CLEAR: begin
          uf_clear_q     <= 1'b1;
          resolve_done_q <= 1'b1;
          cnt_q          <= {CNT_W{1'b0}};
          pending_q      <= 1'b0;
          state_q        <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uf_label_scheduler.sv
`timescale 1ns/1ps
module tb_uf_label_scheduler;

  localparam int N  = 16;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uf_label_scheduler_if #(.ADDR_WIDTH(AW)) pif ();

  logic [1:0]    uf_op;
  logic [AW-1:0] uf_node1, uf_node2, uf_result, lut_wr_addr, lut_wr_data;
  logic          uf_done, uf_idle, uf_clear, lut_wr_en, resolve_done, busy, frame_overrun;

  uf_label_scheduler #(.N_LABELS(N), .ADDR_WIDTH(AW), .FIFO_DEPTH(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .pair_if       (pif),
    .uf_op         (uf_op),
    .uf_node1      (uf_node1),
    .uf_node2      (uf_node2),
    .uf_result     (uf_result),
    .uf_done       (uf_done),
    .uf_idle       (uf_idle),
    .uf_clear      (uf_clear),
    .lut_wr_en     (lut_wr_en),
    .lut_wr_addr   (lut_wr_addr),
    .lut_wr_data   (lut_wr_data),
    .resolve_done  (resolve_done),
    .busy          (busy),
    .frame_overrun (frame_overrun)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- union-find engine model (reset by reset | uf_clear) ----
  logic          eng_rst;
  logic [AW-1:0] parent [N];
  logic          eng_busy;
  int            eng_wait;
  logic          eng_stall;

  assign eng_rst = reset | uf_clear;
  assign uf_idle = ~eng_busy & ~eng_stall;

  function automatic logic [AW-1:0] root_of(input logic [AW-1:0] x);
    logic [AW-1:0] r = x;
    for (int i = 0; i < N; i++) r = parent[r];
    return r;
  endfunction

  always @(posedge clk or posedge eng_rst) begin
    if (eng_rst) begin
      for (int i = 0; i < N; i++) parent[i] <= AW'(i);
      eng_busy  <= 1'b0;
      eng_wait  <= 0;
      uf_done   <= 1'b0;
      uf_result <= '0;
    end else begin
      uf_done <= 1'b0;
      if (eng_busy) begin
        if (eng_wait == 0) begin
          eng_busy <= 1'b0;
          uf_done  <= 1'b1;
        end else begin
          eng_wait <= eng_wait - 1;
        end
      end else if (uf_op == 2'b01) begin
        if (root_of(uf_node1) != root_of(uf_node2)) parent[root_of(uf_node1)] <= root_of(uf_node2);
        eng_busy <= 1'b1;
        eng_wait <= int'($urandom_range(0, 3));
      end else if (uf_op == 2'b10) begin
        uf_result <= root_of(uf_node1);
        eng_busy  <= 1'b1;
        eng_wait  <= int'($urandom_range(0, 3));
      end
    end
  end

  // ---------------- monitor: protocol checks, op log, LUT model ------------
  logic [1:0]    prev_op;
  logic [9:0]    op_log [$];
  logic [AW-1:0] lut_m [N];
  int            n_wr;
  int            n_rdone;

  always @(negedge clk) begin
    if (!reset) begin
      if (uf_op != 2'b00) begin
        check_eq("op_while_engine_idle", 32'(uf_idle), 32'd1);
        check_eq("op_single_cycle", 32'(prev_op), 32'd0);
        op_log.push_back({uf_op, uf_node1, uf_node2});
      end
      if (lut_wr_en) begin
        check_eq("lut_write_order", 32'(lut_wr_addr), 32'(n_wr));
        lut_m[lut_wr_addr] = lut_wr_data;
        n_wr++;
      end
      if (resolve_done) n_rdone++;
    end
    prev_op = uf_op;
  end

  // ---------------- stimulus helpers ---------------------------------------
  logic [AW-1:0] qa [$];
  logic [AW-1:0] qb [$];
  logic [AW-1:0] acc_a [$];
  logic [AW-1:0] acc_b [$];
  logic          exp_ovr;

  task automatic start_frame();
    @(negedge clk);
    #1;
    op_log.delete();
    acc_a.delete();
    acc_b.delete();
    for (int k = 0; k < N; k++) lut_m[k] = '0;
    n_wr    = 0;
    n_rdone = 0;
  endtask

  task automatic add_pair(input int a, input int b);
    qa.push_back(AW'(a));
    qb.push_back(AW'(b));
  endtask

  task automatic add_random(input int n);
    for (int i = 0; i < n; i++) add_pair(int'($urandom_range(0, N-1)), int'($urandom_range(0, N-1)));
  endtask

  // Offers queued pairs; fe_last raises frame_end with the last accepted pair.
  task automatic send_pairs(input bit fe_last, input bit chk_full);
    int i = 0;
    int guard = 0;
    bit full_seen = 1'b0;
    int n = qa.size();
    while (i < n && guard < 4000) begin
      @(negedge clk);
      pif.pair_valid = 1'b1;
      pif.pair_a     = qa[i];
      pif.pair_b     = qb[i];
      pif.frame_end  = fe_last && (i == n-1) && pif.pair_ready;
      if (pif.pair_ready) begin
        acc_a.push_back(qa[i]);
        acc_b.push_back(qb[i]);
        i++;
      end else if (chk_full && !full_seen) begin
        full_seen = 1'b1;
        check_eq("ready_drops_at_depth", 32'(i), 32'd16);
        eng_stall = 1'b0;
      end
      guard++;
    end
    @(negedge clk);
    pif.pair_valid = 1'b0;
    pif.frame_end  = 1'b0;
    eng_stall      = 1'b0;
    check_eq("pairs_accepted", 32'(i), 32'(n));
    if (chk_full) check_eq("ready_drop_seen", 32'(full_seen), 32'd1);
    qa.delete();
    qb.delete();
  endtask

  task automatic pulse_fe();
    @(negedge clk);
    pif.frame_end = 1'b1;
    @(negedge clk);
    pif.frame_end = 1'b0;
  endtask

  task automatic wait_find(input int node);
    bit found = 1'b0;
    int guard = 0;
    while (!found && guard < 3000) begin
      @(negedge clk);
      #1;
      foreach (op_log[j]) if (op_log[j][9:4] == {2'b10, AW'(node)}) found = 1'b1;
      guard++;
    end
    check_eq("find_reached", 32'(found), 32'd1);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_uf_op", 32'(uf_op), 32'd0);
    check_eq("rst_node1", 32'(uf_node1), 32'd0);
    check_eq("rst_node2", 32'(uf_node2), 32'd0);
    check_eq("rst_uf_clear", 32'(uf_clear), 32'd0);
    check_eq("rst_lut_wr_en", 32'(lut_wr_en), 32'd0);
    check_eq("rst_lut_addr", 32'(lut_wr_addr), 32'd0);
    check_eq("rst_lut_data", 32'(lut_wr_data), 32'd0);
    check_eq("rst_resolve_done", 32'(resolve_done), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_overrun", 32'(frame_overrun), 32'd0);
    check_eq("rst_pair_ready", 32'(pif.pair_ready), 32'd0);
  endtask

  // Waits for the sweep, then checks op order, LUT contents and flags
  // against the partition computed directly from the accepted pairs.
  task automatic finish_frame();
    int guard = 0;
    int comp [N];
    logic [9:0] exp_ops [$];
    while (n_rdone == 0 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check_eq("resolve_done_seen", 32'(n_rdone > 0), 32'd1);
    repeat (8) @(negedge clk);
    #1;
    check_eq("resolve_done_count", 32'(n_rdone), 32'd1);
    check_eq("lut_write_count", 32'(n_wr), 32'(N));
    foreach (acc_a[j]) if (acc_a[j] != acc_b[j]) exp_ops.push_back({2'b01, acc_a[j], acc_b[j]});
    for (int k = 0; k < N; k++) exp_ops.push_back({2'b10, AW'(k), 4'd0});
    check_eq("op_count", 32'(op_log.size()), 32'(exp_ops.size()));
    for (int j = 0; j < exp_ops.size() && j < op_log.size(); j++) begin
      if (exp_ops[j][9:8] == 2'b10) check_eq("find_sequence", 32'(op_log[j][9:4]), 32'(exp_ops[j][9:4]));
      else                          check_eq("union_sequence", 32'(op_log[j]), 32'(exp_ops[j]));
    end
    // comp[k] = smallest label in k's equivalence class.
    for (int k = 0; k < N; k++) comp[k] = k;
    foreach (acc_a[j]) begin
      int ca = comp[acc_a[j]];
      int cb = comp[acc_b[j]];
      if (ca != cb) begin
        int lo = (ca < cb) ? ca : cb;
        int hi = (ca < cb) ? cb : ca;
        for (int k = 0; k < N; k++) if (comp[k] == hi) comp[k] = lo;
      end
    end
    for (int k = 0; k < N; k++) begin
      check_eq("lut_root_in_class", 32'(comp[lut_m[k]]), 32'(comp[k]));
      check_eq("lut_common_root", 32'(lut_m[k]), 32'(lut_m[comp[k]]));
    end
    check_eq("busy_after_frame", 32'(busy), 32'd0);
    check_eq("frame_overrun", 32'(frame_overrun), 32'(exp_ovr));
  endtask

  initial begin
    reset          = 1'b1;
    pif.pair_valid = 1'b0;
    pif.pair_a     = '0;
    pif.pair_b     = '0;
    pif.frame_end  = 1'b0;
    eng_stall      = 1'b0;
    exp_ovr        = 1'b0;
    n_wr           = 0;
    n_rdone        = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    reset = 1'b0;

    // Chained and separate equivalences.
    start_frame();
    add_pair(1, 2); add_pair(2, 3); add_pair(5, 6);
    send_pairs(1'b0, 1'b0);
    pulse_fe();
    finish_frame();

    // Self pair is dropped; frame_end coincides with it.
    start_frame();
    add_pair(4, 4);
    send_pairs(1'b1, 1'b0);
    finish_frame();

    // 20 back-to-back pairs with the engine held off: FIFO fills to 16.
    start_frame();
    add_random(20);
    eng_stall = 1'b1;
    send_pairs(1'b0, 1'b1);
    pulse_fe();
    finish_frame();

    // frame_end together with the 3rd accepted pair.
    start_frame();
    add_random(3);
    send_pairs(1'b1, 1'b0);
    finish_frame();

    // Random frames.
    for (int f = 0; f < 4; f++) begin
      int n = int'($urandom_range(0, 12));
      bit fe_with_pair = (n > 0) && ($urandom_range(0, 1) == 1);
      start_frame();
      add_random(n);
      send_pairs(fe_with_pair, 1'b0);
      if (!fe_with_pair) pulse_fe();
      finish_frame();
    end

    // Second frame_end during the sweep.
    start_frame();
    add_random(6);
    send_pairs(1'b0, 1'b0);
    pulse_fe();
    wait_find(0);
    pulse_fe();
    exp_ovr = 1'b1;
    finish_frame();

    // Reset while waiting on the FIND of label 7.
    start_frame();
    add_random(5);
    send_pairs(1'b1, 1'b0);
    wait_find(7);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    repeat (2) @(negedge clk);
    reset   = 1'b0;
    exp_ovr = 1'b0;
    start_frame();
    add_random(7);
    send_pairs(1'b0, 1'b0);
    pulse_fe();
    finish_frame();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
